// File: rtl/bcd_adder_fnd_scan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : bcd_adder_fnd_scan                                              |
// | Brief    : Serial multi-digit packed-BCD adder with multiplexed FND scan.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module bcd_adder_fnd_scan #(
    parameter int DIGITS       = 2,
    parameter int CLK_DIV      = 1000,
    parameter int COMMON_ANODE = 0,
    parameter int BLANK_LZ     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [4*DIGITS-1:0]     a,
    input  logic [4*DIGITS-1:0]     b,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [4*(DIGITS+1)-1:0] sum_bcd,
    output logic [7:0]              seg,
    output logic [DIGITS:0]         com
);

    localparam int c_IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_CW = $clog2(CLK_DIV);
    localparam int c_PW = $clog2(DIGITS + 1);

    localparam logic [c_IW-1:0] c_LAST    = c_IW'(DIGITS - 1);
    localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(CLK_DIV - 1);
    localparam logic [c_PW-1:0] c_POS_MAX = c_PW'(DIGITS);
    localparam logic [7:0]      c_SEG_OFF = (COMMON_ANODE != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS:0] c_COM_OFF = {(DIGITS+1){COMMON_ANODE != 0}};
    localparam logic [7:0]      c_SEG_E   = 8'h79;

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_ADD  = 1'b1;

    logic [0:0]              r_state;
    logic [0:0]              w_state_nxt;
    logic                    w_load;
    logic                    w_last;

    logic [4*DIGITS-1:0]     r_sh_a;
    logic [4*DIGITS-1:0]     r_sh_b;
    logic [4*(DIGITS+1)-1:0] r_sh_sum;
    logic                    r_sh_err;
    logic                    r_carry;
    logic [c_IW-1:0]         r_idx;

    logic [3:0]              w_da;
    logic [3:0]              w_db;
    logic [4:0]              w_s;
    logic [3:0]              w_digit;
    logic                    w_cout;
    logic [4*(DIGITS+1)-1:0] w_sum_nxt;
    logic                    w_op_err;

    logic [c_CW-1:0]         r_cnt;
    logic [c_PW-1:0]         r_pos;
    logic [DIGITS:0]         w_show;
    logic                    w_seen;
    logic [3:0]              w_disp_digit;
    logic [7:0]              w_seg_act;
    logic [DIGITS:0]         w_com_act;

    function automatic logic [7:0] f_seg7(input logic [3:0] d);
        case (d)
            4'd0:    f_seg7 = 8'h3F;
            4'd1:    f_seg7 = 8'h06;
            4'd2:    f_seg7 = 8'h5B;
            4'd3:    f_seg7 = 8'h4F;
            4'd4:    f_seg7 = 8'h66;
            4'd5:    f_seg7 = 8'h6D;
            4'd6:    f_seg7 = 8'h7D;
            4'd7:    f_seg7 = 8'h07;
            4'd8:    f_seg7 = 8'h7F;
            4'd9:    f_seg7 = 8'h6F;
            default: f_seg7 = 8'h00;
        endcase
    endfunction

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start)  w_state_nxt = c_ADD;
            c_ADD:   if (w_last) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy   = (r_state == c_ADD);
        w_load = (r_state == c_IDLE) && start;
        w_last = (r_state == c_ADD) && (r_idx == c_LAST);
    end

    always_comb begin
        w_op_err = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if ((a[4*i +: 4] > 4'd9) || (b[4*i +: 4] > 4'd9)) w_op_err = 1'b1;
        end
    end

    always_comb begin
        w_da = r_sh_a[{r_idx, 2'b00} +: 4];
        w_db = r_sh_b[{r_idx, 2'b00} +: 4];
        w_s  = {1'b0, w_da} + {1'b0, w_db} + {4'b0000, r_carry};
        if (w_s > 5'd9) begin
            w_digit = w_s[3:0] + 4'd6;
            w_cout  = 1'b1;
        end else begin
            w_digit = w_s[3:0];
            w_cout  = 1'b0;
        end
    end

    // Shadow with the current digit (and final carry) folded in, so commit is atomic
    always_comb begin
        w_sum_nxt = r_sh_sum;
        w_sum_nxt[{r_idx, 2'b00} +: 4] = w_digit;
        if (w_last) w_sum_nxt[4*DIGITS +: 4] = {3'b000, w_cout};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_sh_sum <= '0;
            r_sh_err <= 1'b0;
            r_carry  <= 1'b0;
            r_idx    <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            sum_bcd  <= '0;
        end else begin
            done <= w_last;
            if (w_load) begin
                r_sh_a   <= a;
                r_sh_b   <= b;
                r_sh_err <= w_op_err;
                r_sh_sum <= '0;
                r_carry  <= 1'b0;
                r_idx    <= '0;
            end else if (busy) begin
                r_sh_sum <= w_sum_nxt;
                r_carry  <= w_cout;
                r_idx    <= r_idx + 1'b1;
                if (w_last) begin
                    r_idx   <= '0;
                    err     <= r_sh_err;
                    sum_bcd <= r_sh_err ? '0 : w_sum_nxt;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            r_pos <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt <= '0;
            r_pos <= (r_pos == c_POS_MAX) ? '0 : r_pos + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A position is lit if it or any more significant digit is non-zero
    always_comb begin
        w_seen = 1'b0;
        w_show = '0;
        for (int i = DIGITS; i >= 0; i--) begin
            w_seen    = w_seen | (sum_bcd[4*i +: 4] != 4'd0) | (i == 0);
            w_show[i] = w_seen | (BLANK_LZ == 0);
        end
    end

    always_comb begin
        w_disp_digit = sum_bcd[{r_pos, 2'b00} +: 4];
        w_com_act    = (DIGITS+1)'(1) << r_pos;
        if (err)                w_seg_act = c_SEG_E;
        else if (w_show[r_pos]) w_seg_act = f_seg7(w_disp_digit);
        else                    w_seg_act = 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= c_SEG_OFF;
            com <= c_COM_OFF;
        end else begin
            seg <= w_seg_act ^ c_SEG_OFF;
            com <= w_com_act ^ c_COM_OFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bcd_adder_fnd_scan.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_bcd_adder_fnd_scan                                           |
// | Brief    : Scoreboard bench for the serial BCD adder and FND scan.         |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_bcd_adder_fnd_scan;

    localparam int DIGITS  = 2;
    localparam int CLK_DIV = 4;

    typedef struct packed {
        logic [11:0] sum;
        logic        err;
    } exp_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  a     = 8'h00;
    logic [7:0]  b     = 8'h00;
    logic        busy;
    logic        done;
    logic        err;
    logic [11:0] sum_bcd;
    logic [7:0]  seg;
    logic [2:0]  com;

    exp_t sb_q[$];
    exp_t m_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_done  = 0;

    bcd_adder_fnd_scan #(
        .DIGITS      (DIGITS),
        .CLK_DIV     (CLK_DIV),
        .COMMON_ANODE(0),
        .BLANK_LZ    (1)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .sum_bcd(sum_bcd),
        .seg    (seg),
        .com    (com)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal reference: convert operands to integers, add, convert back
    function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
        exp_t r;
        int   s;
        r.err = (x[3:0] > 9) || (x[7:4] > 9) || (y[3:0] > 9) || (y[7:4] > 9);
        s = x[7:4] * 10 + x[3:0] + y[7:4] * 10 + y[3:0];
        r.sum = r.err ? 12'h000 : {4'(s / 100), 4'((s / 10) % 10), 4'(s % 10)};
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            check("sb_nonempty", 32'(sb_q.size() != 0), 1);
            if (sb_q.size() != 0) begin
                m_e = sb_q.pop_front();
                check("sum_bcd", sum_bcd, m_e.sum);
                check("err", err, m_e.err);
            end
        end
    end

    task automatic do_op(input logic [7:0] x, input logic [7:0] y);
        int lat;
        bit found;
        sb_q.push_back(model(x, y));
        @(posedge clk); #1 a = x; b = y; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        lat = 0;
        found = 1'b0;
        for (int c = 1; c <= 20 && !found; c++) begin
            @(negedge clk);
            if (c == 1) check("busy_after_start", busy, 1);
            if (done) begin
                found = 1'b1;
                lat = c;
            end
        end
        check("done_latency", lat, 3);
        check("busy_at_done", busy, 0);
    endtask

    task automatic check_display(input string tag, input logic [7:0] s0,
                                 input logic [7:0] s1, input logic [7:0] s2);
        logic [2:0] seen;
        logic [2:0] prev;
        seen = 3'b000;
        @(posedge clk);
        @(negedge clk);
        prev = com;
        for (int c = 0; c < 3 * CLK_DIV + 2; c++) begin
            check({tag, "_com_onehot"}, 32'($onehot(com)), 1);
            if (com != prev) check({tag, "_com_order"}, com, {prev[1:0], prev[2]});
            case (com)
                3'b001: begin check({tag, "_pos0"}, seg, s0); seen[0] = 1'b1; end
                3'b010: begin check({tag, "_pos1"}, seg, s1); seen[1] = 1'b1; end
                3'b100: begin check({tag, "_pos2"}, seg, s2); seen[2] = 1'b1; end
                default: ;
            endcase
            prev = com;
            @(negedge clk);
        end
        check({tag, "_all_positions"}, seen, 3'b111);
    endtask

    initial begin
        int n0;
        int times[$];

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_sum", sum_bcd, 12'h000);
        check("rst_seg", seg, 8'h00);
        check("rst_com", com, 3'b000);
        rst = 1'b0;
        check_display("rst", 8'h3F, 8'h00, 8'h00);

        do_op(8'h47, 8'h38);
        check_display("s085", 8'h6D, 8'h7F, 8'h00);
        do_op(8'h99, 8'h99);
        check_display("s198", 8'h7F, 8'h6F, 8'h06);
        do_op(8'h1A, 8'h05);
        check_display("serr", 8'h79, 8'h79, 8'h79);
        do_op(8'h01, 8'h02);
        check_display("s003", 8'h4F, 8'h00, 8'h00);

        // start re-asserted while the addition is in flight
        n0 = n_done;
        sb_q.push_back(model(8'h12, 8'h34));
        @(posedge clk); #1 a = 8'h12; b = 8'h34; start = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 start = 1'b0;
        repeat (8) @(negedge clk);
        check("ignored_start_dones", n_done - n0, 1);

        // start held high: back-to-back operations
        n0 = n_done;
        repeat (3) sb_q.push_back(model(8'h25, 8'h25));
        @(posedge clk); #1 a = 8'h25; b = 8'h25; start = 1'b1;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (done) times.push_back(c);
            if (c == 7) start = 1'b0;
        end
        check("held_done_count", times.size(), 3);
        if (times.size() == 3) begin
            check("held_first_latency", times[0], 3);
            check("held_spacing_1", times[1] - times[0], DIGITS + 1);
            check("held_spacing_2", times[2] - times[1], DIGITS + 1);
        end

        // reset during the first ADD cycle aborts the operation
        n0 = n_done;
        @(posedge clk); #1 a = 8'h50; b = 8'h50; start = 1'b1;
        @(posedge clk); #1 start = 1'b0; rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_sum", sum_bcd, 12'h000);
        check("abort_com", com, 3'b000);
        repeat (6) @(negedge clk);
        check("abort_no_done", n_done - n0, 0);
        do_op(8'h50, 8'h50);
        check("after_abort_sum", sum_bcd, 12'h100);

        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
`default_nettype wire
